// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-triggered IRQ latch, mask, fixed priority, inta/ack/RETI handshake.
// Optional macro INTC_IRQ_SYNC_EN adds a two-flop synchronizer on every irq line.
module interrupt_controller #(
  parameter int DBITS    = 32,
  parameter int NUM_SRC  = 4,
  parameter int IDN_BASE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_in,
  input  logic               intaSig,
  input  logic               isReti,
  output logic               inta,
  output logic [DBITS-1:0]   idn,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic               in_service
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  logic [1:0]         r_state;
  logic [IW-1:0]      r_sel;
  logic [DBITS-1:0]   r_idn;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_irq_prev;

  logic [NUM_SRC-1:0] w_irq;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_elig;
  logic [IW-1:0]      w_sel;
  logic               w_any;
  logic               w_ack;
  logic [DBITS-1:0]   w_idn_nxt;

`ifdef INTC_IRQ_SYNC_EN
  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq = r_sync2;
`else
  assign w_irq = irq;
`endif

  assign w_rise = w_irq & ~r_irq_prev;
  assign w_ack  = (r_state == S_REQ) && intaSig;
  assign w_clr  = w_ack ? (NUM_SRC'(1) << r_sel) : '0;
  assign w_elig = r_pending & r_mask;
  assign w_any  = |w_elig;

  // Scan downwards so the lowest set index wins.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel = IW'(i);
    end
  end

  assign w_idn_nxt = DBITS'(IDN_BASE) + DBITS'(w_sel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_mask     <= '0;
    end else begin
      r_irq_prev <= w_irq;
      // A new rise on the acked line keeps the bit set.
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) r_mask <= mask_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_idn   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_REQ;
            r_sel   <= w_sel;
            r_idn   <= w_idn_nxt;
          end
        end
        S_REQ: begin
          if (intaSig) r_state <= S_SVC;
        end
        S_SVC: begin
          if (isReti) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inta       = (r_state == S_REQ);
  assign in_service = (r_state == S_SVC);
  assign idn        = r_idn;
  assign pending    = r_pending;
  assign mask       = r_mask;

endmodule
